buffer_seq: RTL and testbench
=============================

// Module: buffer_seq
// PURPOSE
//  Sequencer for the shift buffer in the HOG pixel path: takes a raster pixel stream,
//  tracks column/row, and drives the buffer's shift enable and clear.
//  Flags the cycles where the buffer holds a full WIN-pixel horizontal window for the next stage.
//  Inserts a one-cycle clear bubble at each line end; frame start, end and abort come from the stream.
// PARAMETERS
//  WIN    4    window length; equals the controlled buffer's DEPTH; 2 <= WIN <= IMG_W
//  IMG_W  160  pixels per line
//  IMG_H  120  lines per frame
//  COL_W  8    column counter width, >= clog2(IMG_W)
//  ROW_W  7    row counter width, >= clog2(IMG_H)
// PORTS
//  clk         in   1      the clock
//  rst         in   1      synchronous, active-high reset
//  i_valid     in   1      upstream pixel valid
//  i_sof       in   1      qualifies i_valid: pixel is row 0, col 0 of a frame
//  o_ready     out  1      sequencer can take a pixel; accept = i_valid & o_ready
//  i_ready     in   1      downstream can take a window next cycle
//  buf_shift   out  1      to buffer i_valid; equals accept (combinational)
//  buf_clear   out  1      to buffer clear (registered)
//  o_win_valid out  1      buffer output holds a full window (registered pulse)
//  o_col       out  COL_W  column of newest pixel in the window, valid with o_win_valid
//  o_row       out  ROW_W  row of the window, valid with o_win_valid
//  o_eof       out  1      high with the last window of the frame
//  o_drop      out  1      pulse: a non-SOF pixel was discarded in IDLE
// BEHAVIOUR
//  Reset: state=IDLE; col=0; row=0; all registered outputs 0.
//   o_ready=1 in IDLE, so accept=i_valid; buf_shift follows.
//  FSM states: IDLE, FILL, RUN, LINE_END, DONE.
//  - IDLE
//     accept with i_sof -> FILL, col=1, row=0.
//     accept without i_sof -> discard: buf_shift=0, o_drop=1 next cycle.
//  - FILL (col < WIN-1): o_ready=1 regardless of i_ready.
//     Accept increments col; at col=WIN-1 go to RUN.
//  - RUN: o_ready=i_ready.
//     Accept -> next cycle o_win_valid=1 with o_col=col and o_row=row, aligned with buffer output.
//     Accept at col=IMG_W-1 -> LINE_END, or DONE if row=IMG_H-1.
//  - LINE_END: o_ready=0; buf_clear=1 for one cycle; col=0; row++ -> FILL.
//  - DONE: o_ready=0; buf_clear=1; o_eof was asserted with the final window -> IDLE.
//  Latency: accept at cycle t -> o_win_valid at t+1. No stall holding: ready gates accept,
//   so every window pulse is consumed. Max throughput 1 window/cycle inside a line.
//  Simultaneous events:
//   - i_sof accepted in FILL or RUN = abort. buf_clear=1 next cycle; the SOF pixel is taken
//     as col 0, row 0 (col=1 -> FILL). No o_win_valid for the SOF pixel.
//   - An abort also clears the buffer, and the SOF pixel shifts in the same cycle:
//     the buffer applies clear before shift.
//  Widths: col/row wrap never occurs; they reset at line/frame end.
//   IMG_W-1 must fit COL_W and IMG_H-1 must fit ROW_W (elaboration check).
//  Reset mid-frame: immediate return to IDLE; no o_eof; buffer reset by the shared rst.
//  i_valid=0 in any state: no shift, counters hold.
// STRUCTURE
//  Shared header buffer_defs.vh: state encodings (3-bit localparams IDLE..DONE)
//   and the SEQ_WIN default shared with buffer DEPTH.
//  One sub-module, pos_counter: col/row counter with inc, line_wrap and clr inputs,
//   and is_last_col/is_last_row outputs. The FSM and output registers stay in buffer_seq.
//  Instantiated next to buffer with buf_shift->i_valid and buf_clear->clear.
// TESTING (WIN=4, IMG_W=8, IMG_H=2)
//  1 Full frame, i_valid and i_ready held high
//    -> 10 o_win_valid pulses, o_col 3..7 for rows 0 and 1; 1-cycle gap after col 7.
//    -> o_eof with row 1 col 7; back to IDLE.
//  2 i_ready low for 3 cycles at row 0 col 5
//    -> o_ready=0; no shift; window col 5 appears 1 cycle after i_ready rises.
//    -> window data equals pixels 2..5.
//  3 Three non-SOF pixels in IDLE -> 3 o_drop pulses, no buf_shift, state stays IDLE.
//  4 SOF at row 1 col 2
//    -> buf_clear next cycle; counters restart; next window is o_col=3, o_row=0.
//  5 rst asserted in RUN at row 1 col 5 -> next cycle all outputs 0, state IDLE, no o_eof.
//  6 i_valid toggled 1010 throughout a frame -> same window sequence as test 1, no duplicates.

Source files
------------

// File: rtl/buffer_seq_pkg.sv
// Shared definitions for the shift-buffer sequencer.
//   seq_state_t : 3-bit FSM state encoding (IDLE..DONE), also exposed on the
//                 debug port of buffer_seq.
//   SEQ_WIN     : default window length; the controlled buffer's DEPTH must
//                 use the same value.
package buffer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FILL     = 3'd1,
        ST_RUN      = 3'd2,
        ST_LINE_END = 3'd3,
        ST_DONE     = 3'd4
    } seq_state_t;

    localparam int SEQ_WIN = 4;

endpackage

// File: rtl/buffer_seq_if.sv
// Stream, buffer-control and window signals of the shift-buffer sequencer.
//   i_valid/i_sof/o_ready : upstream pixel stream (i_sof marks row 0, col 0)
//   i_ready               : downstream can take a window next cycle
//   buf_shift/buf_clear   : drive the shift buffer's i_valid and clear
//   o_win_valid/o_col/o_row/o_eof : window flag and its position
//   o_drop                : a non-SOF pixel was discarded while idle
// Handshake: a pixel is transferred in every cycle where i_valid and o_ready
// are both high; o_ready never depends on i_valid, and a transferred pixel
// is never presented to the buffer twice. o_ready already folds in i_ready,
// so every o_win_valid pulse is consumed without stall holding.
// The master modport is the stream/bench side, slave is the sequencer.
interface buffer_seq_if #(
    parameter int COL_W = 8,
    parameter int ROW_W = 7
);
    logic             i_valid;
    logic             i_sof;
    logic             o_ready;
    logic             i_ready;
    logic             buf_shift;
    logic             buf_clear;
    logic             o_win_valid;
    logic [COL_W-1:0] o_col;
    logic [ROW_W-1:0] o_row;
    logic             o_eof;
    logic             o_drop;

    modport master (
        output i_valid, i_sof, i_ready,
        input  o_ready, buf_shift, buf_clear, o_win_valid, o_col, o_row, o_eof, o_drop
    );

    modport slave (
        input  i_valid, i_sof, i_ready,
        output o_ready, buf_shift, buf_clear, o_win_valid, o_col, o_row, o_eof, o_drop
    );
endinterface

// File: rtl/buffer_seq_pos_counter.sv
// Column/row position counter for the sequencer.
//   clk, rst    : clock, synchronous active-high reset
//   inc         : advance the column
//   line_wrap   : column back to 0, row + 1
//   clr         : restart at row 0; col becomes 1 when inc is also set
//                 (an accepted SOF pixel occupies col 0)
//   col, row    : current position (column of the next pixel to arrive)
//   is_last_col : col == IMG_W-1
//   is_last_row : row == IMG_H-1
module pos_counter #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int COL_W = 8,
    parameter int ROW_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             line_wrap,
    input  logic             clr,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             is_last_col,
    output logic             is_last_row
);

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= inc ? COL_W'(1) : '0;
            row <= '0;
        end else if (line_wrap) begin
            col <= '0;
            row <= row + ROW_W'(1);
        end else if (inc) begin
            col <= col + COL_W'(1);
        end
    end

    assign is_last_col = (col == COL_W'(IMG_W - 1));
    assign is_last_row = (row == ROW_W'(IMG_H - 1));

endmodule

// File: rtl/buffer_seq.sv
// Sequencer for the shift buffer in the HOG pixel path. Tracks column/row
// of a raster pixel stream, drives the buffer's shift enable and clear, and
// flags the cycles in which the buffer holds a full WIN-pixel window.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : stream / buffer-control / window signals (buffer_seq_if)
//   dbg_state : current FSM state
module buffer_seq
    import buffer_seq_pkg::*;
#(
    parameter int WIN   = SEQ_WIN,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int COL_W = 8,
    parameter int ROW_W = 7
) (
    input  logic         clk,
    input  logic         rst,
    buffer_seq_if.slave  bus,
    output seq_state_t   dbg_state
);

    if (WIN < 2 || WIN > IMG_W) begin : g_win_chk
        $error("buffer_seq: WIN must satisfy 2 <= WIN <= IMG_W");
    end
    if (IMG_W - 1 >= 2 ** COL_W) begin : g_col_chk
        $error("buffer_seq: IMG_W-1 does not fit in COL_W bits");
    end
    if (IMG_H - 1 >= 2 ** ROW_W) begin : g_row_chk
        $error("buffer_seq: IMG_H-1 does not fit in ROW_W bits");
    end

    // With WIN=2 the SOF pixel alone leaves one pixel to fill, so the next
    // accepted pixel already completes a window.
    localparam seq_state_t FIRST_ST = (WIN == 2) ? ST_RUN : ST_FILL;

    seq_state_t       state, state_d;
    logic             ready, accept, sof_acc, pix_acc;
    logic             shift, cnt_inc, cnt_wrap, cnt_clr;
    logic             win_d, eof_d, drop_d, clear_d;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             is_last_col, is_last_row;

    pos_counter #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .COL_W(COL_W), .ROW_W(ROW_W)
    ) u_pos (
        .clk(clk), .rst(rst),
        .inc(cnt_inc), .line_wrap(cnt_wrap), .clr(cnt_clr),
        .col(col), .row(row),
        .is_last_col(is_last_col), .is_last_row(is_last_row)
    );

    // Only RUN produces windows, so only RUN needs downstream room.
    always_comb begin
        ready = 1'b0;
        case (state)
            ST_IDLE, ST_FILL: ready = 1'b1;
            ST_RUN:           ready = bus.i_ready;
            default:          ready = 1'b0;
        endcase
    end

    assign accept  = bus.i_valid & ready;
    assign sof_acc = accept & bus.i_sof;
    assign pix_acc = accept & ~bus.i_sof;

    always_comb begin
        state_d  = state;
        shift    = 1'b0;
        cnt_inc  = 1'b0;
        cnt_wrap = 1'b0;
        cnt_clr  = 1'b0;
        win_d    = 1'b0;
        eof_d    = 1'b0;
        drop_d   = 1'b0;
        clear_d  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sof_acc) begin
                    shift   = 1'b1;
                    cnt_clr = 1'b1;
                    cnt_inc = 1'b1;
                    state_d = FIRST_ST;
                end else if (pix_acc) begin
                    drop_d = 1'b1;
                end
            end
            ST_FILL, ST_RUN: begin
                if (sof_acc) begin
                    // Abort: restart the frame with this pixel as col 0; the
                    // stale buffer contents are cleared next cycle.
                    shift   = 1'b1;
                    cnt_clr = 1'b1;
                    cnt_inc = 1'b1;
                    clear_d = 1'b1;
                    state_d = FIRST_ST;
                end else if (pix_acc) begin
                    shift = 1'b1;
                    if (state == ST_FILL) begin
                        cnt_inc = 1'b1;
                        if (col == COL_W'(WIN - 2)) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        win_d = 1'b1;
                        if (is_last_col) begin
                            clear_d = 1'b1;
                            eof_d   = is_last_row;
                            state_d = is_last_row ? ST_DONE : ST_LINE_END;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end
            end
            ST_LINE_END: begin
                cnt_wrap = 1'b1;
                state_d  = ST_FILL;
            end
            ST_DONE: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // The window flag lands on the same edge that shifts the newest pixel
    // into the buffer, so it lines up with the buffer's output.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.buf_clear   <= 1'b0;
            bus.o_win_valid <= 1'b0;
            bus.o_eof       <= 1'b0;
            bus.o_drop      <= 1'b0;
            bus.o_col       <= '0;
            bus.o_row       <= '0;
        end else begin
            bus.buf_clear   <= clear_d;
            bus.o_win_valid <= win_d;
            bus.o_eof       <= eof_d;
            bus.o_drop      <= drop_d;
            if (win_d) begin
                bus.o_col <= col;
                bus.o_row <= row;
            end
        end
    end

    assign bus.o_ready   = ready;
    assign bus.buf_shift = shift;
    assign dbg_state     = state;

endmodule

// File: tb/tb_buffer_seq.sv
module tb_buffer_seq;
    import buffer_seq_pkg::*;

    localparam int WIN   = 4;
    localparam int IMG_W = 8;
    localparam int IMG_H = 2;
    localparam int COL_W = 8;
    localparam int ROW_W = 7;
    localparam int DW    = 8 * WIN;
    localparam int EW    = ROW_W + COL_W + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    buffer_seq_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();
    seq_state_t dbg_state;

    buffer_seq #(
        .WIN(WIN), .IMG_W(IMG_W), .IMG_H(IMG_H), .COL_W(COL_W), .ROW_W(ROW_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    // Behavioural shift buffer driven by the sequencer (clear before shift).
    logic [7:0] pix;
    logic [7:0] tb_buf [WIN];
    always @(posedge clk) begin : tb_buffer
        logic [7:0] t [WIN];
        for (int i = 0; i < WIN; i++) t[i] = (rst || bus.buf_clear) ? 8'h00 : tb_buf[i];
        if (!rst && bus.buf_shift) begin
            for (int i = WIN - 1; i > 0; i--) t[i] = t[i-1];
            t[0] = pix;
        end
        for (int i = 0; i < WIN; i++) tb_buf[i] <= t[i];
    end

    function automatic logic [DW-1:0] buf_word();
        logic [DW-1:0] w = '0;
        for (int i = WIN - 1; i >= 0; i--) w = (w << 8) | DW'(tb_buf[i]);
        return w;
    endfunction

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    int n_win_seen = 0;
    int n_eof_seen = 0;
    int n_drop_seen = 0;
    logic [EW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame position as a linear pixel index, plus the pixels the buffer
    // should hold. Expected registered outputs apply to the next cycle.
    bit         m_in_frame = 0;
    int         m_idx = 0;
    bit         m_bubble = 0;
    logic [7:0] mq [$];
    bit exp_wv = 0, exp_eof = 0, exp_drop = 0, exp_clr = 0;

    function automatic logic [DW-1:0] mq_window();
        logic [DW-1:0] w = '0;
        int j;
        for (int k = 0; k < WIN; k++) begin
            j = mq.size() - WIN + k;
            w = (w << 8) | ((j >= 0) ? DW'(mq[j]) : '0);
        end
        return w;
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input bit s, input bit r, input bit rs);
        logic [EW-1:0] e;
        bit e_ready, e_shift, acc;
        bit nwv, neof, ndrop, nclr;
        int col, row;

        check("win_valid", bus.o_win_valid, exp_wv);
        check("eof", bus.o_eof, exp_eof);
        check("drop", bus.o_drop, exp_drop);
        check("buf_clear", bus.buf_clear, exp_clr);
        if (bus.o_eof) n_eof_seen++;
        if (bus.o_drop) n_drop_seen++;
        if (bus.o_win_valid) begin
            n_win_seen++;
            if (exp_q.size() == 0) begin
                check("win_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("o_row", bus.o_row, e[EW-1 -: ROW_W]);
                check("o_col", bus.o_col, e[DW+COL_W-1 -: COL_W]);
                check("win_data", buf_word(), e[DW-1:0]);
            end
        end

        bus.i_valid = v;
        bus.i_sof   = s;
        bus.i_ready = r;
        rst         = rs;
        pix         = 8'($urandom_range(0, 255));
        #1;
        e_ready = m_bubble ? 1'b0
                : ((m_in_frame && (m_idx % IMG_W) >= WIN - 1) ? r : 1'b1);
        e_shift = v && e_ready && (m_in_frame || s);
        if (!rs) begin
            check("o_ready", bus.o_ready, e_ready);
            check("buf_shift", bus.buf_shift, e_shift);
            if (!m_in_frame && !m_bubble) check("state_idle", dbg_state, ST_IDLE);
        end

        nwv = 0; neof = 0; ndrop = 0; nclr = 0;
        if (rs) begin
            m_in_frame = 0; m_idx = 0; m_bubble = 0;
            mq.delete();
        end else begin
            if (exp_clr) mq.delete();
            if (e_shift) begin
                mq.push_back(pix);
                if (mq.size() > WIN) void'(mq.pop_front());
            end
            acc = v && e_ready;
            if (m_bubble) begin
                m_bubble = 0;
            end else if (acc) begin
                if (s) begin
                    nclr = m_in_frame;
                    m_in_frame = 1;
                    m_idx = 1;
                end else if (!m_in_frame) begin
                    ndrop = 1;
                end else begin
                    col = m_idx % IMG_W;
                    row = m_idx / IMG_W;
                    if (col >= WIN - 1) begin
                        nwv = 1;
                        exp_q.push_back({ROW_W'(row), COL_W'(col), mq_window()});
                    end
                    m_idx++;
                    if (col == IMG_W - 1) begin
                        m_bubble = 1;
                        nclr = 1;
                        if (row == IMG_H - 1) begin
                            neof = 1;
                            m_in_frame = 0;
                            m_idx = 0;
                        end
                    end
                end
            end
        end
        exp_wv = nwv; exp_eof = neof; exp_drop = ndrop; exp_clr = nclr;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        bit r, s, rs, done;
        bus.i_valid = 0; bus.i_sof = 0; bus.i_ready = 1; pix = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        // reset state
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_ready", bus.o_ready, 1);
        check("rst_win_valid", bus.o_win_valid, 0);
        check("rst_clear", bus.buf_clear, 0);
        check("rst_col", bus.o_col, 0);
        check("rst_row", bus.o_row, 0);
        check("rst_eof", bus.o_eof, 0);
        check("rst_drop", bus.o_drop, 0);

        // full frame, valid and ready held high
        n_win_seen = 0; n_eof_seen = 0;
        step(1, 1, 1, 0);
        repeat (22) step(1, 0, 1, 0);
        repeat (3) step(0, 0, 1, 0);
        check("full_frame_windows", n_win_seen, 10);
        check("full_frame_eof", n_eof_seen, 1);

        // i_ready low for 3 cycles at row 0 col 5
        cnt = 0;
        step(1, 1, 1, 0);
        repeat (25) begin
            r = !(m_in_frame && m_idx == 5 && cnt < 3);
            if (!r) cnt++;
            step(1, 0, r, 0);
        end
        repeat (3) step(0, 0, 1, 0);

        // non-SOF pixels while idle
        n_drop_seen = 0;
        repeat (3) step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        check("idle_drops", n_drop_seen, 3);

        // SOF abort at row 1 col 2
        done = 0;
        step(1, 1, 1, 0);
        repeat (40) begin
            s = !done && m_in_frame && m_idx == IMG_W + 2;
            if (s) done = 1;
            step(1, s, 1, 0);
        end
        repeat (3) step(0, 0, 1, 0);

        // reset in RUN at row 1 col 5
        done = 0; n_eof_seen = 0;
        step(1, 1, 1, 0);
        repeat (20) begin
            rs = !done && m_in_frame && m_idx == IMG_W + 5;
            if (rs) done = 1;
            step(1, 0, 1, rs);
        end
        step(0, 0, 1, 0);
        check("reset_no_eof", n_eof_seen, 0);

        // i_valid toggling 1010 through a frame
        n_win_seen = 0;
        step(1, 1, 1, 0);
        for (int i = 0; i < 44; i++) step(i % 2 == 1, 0, 1, 0);
        repeat (3) step(0, 0, 1, 0);
        check("toggle_windows", n_win_seen, 10);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 300) == 0);
        end
        repeat (4) step(0, 0, 1, 0);
        check("pending_windows", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
